vga_timing_checker: RTL and testbench

Synthesisable, parametrised VGA timing monitor that sits beside `Genius_top_level` and watches the generated `VGA_HS`, `VGA_VS` and `DISP_EN` outputs. It locks onto the sync stream, measures line period, sync widths, frame period and active-region size against the configured video mode, and reports sticky error flags, a saturating error count and a per-frame pulse. It replaces manual waveform inspection of the `$monitor` trace with an in-fabric and in-bench self-check usable at any resolution.

---
 rtl/vga_timing_checker.sv | 186 ++++++++++++++++++
 tb/tb_vga_timing_checker.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_checker.sv
// VGA sync-stream monitor: locks onto HS/VS and checks line, sync,
// frame and active-region timing against the configured video mode.
module vga_timing_checker #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int ERR_W     = 8
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             pix_en,
  input  logic             VGA_HS,
  input  logic             VGA_VS,
  input  logic             DISP_EN,
  output logic             locked,
  output logic             frame_done,
  output logic [4:0]       err_flags,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int F_TOTAL = H_TOTAL * V_TOTAL;
  localparam int HW = $clog2(H_TOTAL) + 1;
  localparam int FW = $clog2(F_TOTAL) + 1;
  localparam int VW = $clog2(V_TOTAL) + 1;

  typedef enum logic [1:0] {
    IDLE,
    HLOCK,
    LOCKED
  } state_t;

  state_t state_q;

  logic          hs_prev_q, vs_prev_q;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [HW-1:0] hs_w_q, hs_w_d;
  logic [HW-1:0] de_cnt_q, de_cnt_d;
  logic [FW-1:0] f_cnt_q, f_cnt_d;
  logic [FW-1:0] vs_w_q, vs_w_d;
  logic [VW-1:0] act_q, act_d;
  logic [VW-1:0] act_closed;

  logic             locked_q, frame_done_q;
  logic [4:0]       err_flags_q;
  logic [ERR_W-1:0] err_count_q;
  logic [15:0]      frame_count_q;

  logic hs_a, vs_a;
  logic hs_rise, hs_fall, vs_rise, vs_fall;
  logic chk_h, chk_v;
  logic [4:0] errs;

  assign hs_a    = (VGA_HS == HS_POL);
  assign vs_a    = (VGA_VS == VS_POL);
  assign hs_rise = hs_a & ~hs_prev_q;
  assign hs_fall = ~hs_a & hs_prev_q;
  assign vs_rise = vs_a & ~vs_prev_q;
  assign vs_fall = ~vs_a & vs_prev_q;
  assign chk_h   = (state_q != IDLE);
  assign chk_v   = (state_q == LOCKED);

  // A line closing on this sample is counted before the frame check
  always_comb begin
    act_closed = act_q;
    if (hs_rise && de_cnt_q != '0 && act_q != '1)
      act_closed = act_q + VW'(1);
  end

  always_comb begin
    h_cnt_d  = h_cnt_q;
    hs_w_d   = hs_w_q;
    de_cnt_d = de_cnt_q;
    f_cnt_d  = f_cnt_q;
    vs_w_d   = vs_w_q;
    act_d    = act_closed;
    if (hs_rise) begin
      h_cnt_d  = '0;
      hs_w_d   = HW'(1);
      de_cnt_d = DISP_EN ? HW'(1) : '0;
    end else begin
      if (h_cnt_q != '1)
        h_cnt_d = h_cnt_q + HW'(1);
      if (hs_a && hs_w_q != '1)
        hs_w_d = hs_w_q + HW'(1);
      if (DISP_EN && de_cnt_q != '1)
        de_cnt_d = de_cnt_q + HW'(1);
    end
    if (vs_rise) begin
      f_cnt_d = '0;
      vs_w_d  = FW'(1);
      act_d   = '0;
    end else begin
      if (f_cnt_q != '1)
        f_cnt_d = f_cnt_q + FW'(1);
      if (vs_a && vs_w_q != '1)
        vs_w_d = vs_w_q + FW'(1);
    end
  end

  // Saturated counters never equal the expected value, so lost sync flags
  always_comb begin
    errs = '0;
    if (chk_h && hs_rise) begin
      errs[0] = (h_cnt_q != HW'(H_TOTAL - 1));
      errs[2] = (de_cnt_q != '0) && (de_cnt_q != HW'(H_VISIBLE));
    end
    if (chk_h && hs_fall)
      errs[1] = (hs_w_q != HW'(H_SYNC));
    if (chk_v && vs_rise) begin
      errs[3] = (f_cnt_q != FW'(F_TOTAL - 1));
      errs[4] = (act_closed != VW'(V_VISIBLE));
    end
    if (chk_v && vs_fall)
      errs[3] = (vs_w_q != FW'(V_SYNC * H_TOTAL));
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= IDLE;
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      h_cnt_q       <= '0;
      hs_w_q        <= '0;
      de_cnt_q      <= '0;
      f_cnt_q       <= '0;
      vs_w_q        <= '0;
      act_q         <= '0;
      locked_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      err_flags_q   <= '0;
      err_count_q   <= '0;
      frame_count_q <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (pix_en) begin
        hs_prev_q   <= hs_a;
        vs_prev_q   <= vs_a;
        h_cnt_q     <= h_cnt_d;
        hs_w_q      <= hs_w_d;
        de_cnt_q    <= de_cnt_d;
        f_cnt_q     <= f_cnt_d;
        vs_w_q      <= vs_w_d;
        act_q       <= act_d;
        err_flags_q <= err_flags_q | errs;
        if (|errs && err_count_q != '1)
          err_count_q <= err_count_q + ERR_W'(1);
        unique case (state_q)
          IDLE: begin
            if (hs_rise)
              state_q <= HLOCK;
          end
          HLOCK: begin
            if (vs_rise) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end
          LOCKED: begin
            if (vs_rise) begin
              frame_done_q  <= 1'b1;
              frame_count_q <= frame_count_q + 16'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign locked      = locked_q;
  assign frame_done  = frame_done_q;
  assign err_flags   = err_flags_q;
  assign err_count   = err_count_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_checker.sv
// Bench for vga_timing_checker: small 14x7 mode, pix_en every 2nd cycle,
// per-frame expectations queued by stimulus and popped on frame_done.
module tb_vga_timing_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic        hs, vs, de;
  logic        locked, frame_done;
  logic [4:0]  err_flags;
  logic [7:0]  err_count;
  logic [15:0] frame_count;

  typedef struct {
    logic [4:0]  flags;
    logic [7:0]  errc;
    logic [15:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic fd_prev = 1'b0;

  always #5 clk = ~clk;

  vga_timing_checker #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .ERR_W(8)
  ) dut (
    .CLOCK_50(clk),
    .reset(reset),
    .pix_en(pix_en),
    .VGA_HS(hs),
    .VGA_VS(vs),
    .DISP_EN(de),
    .locked(locked),
    .frame_done(frame_done),
    .err_flags(err_flags),
    .err_count(err_count),
    .frame_count(frame_count)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every frame_done pulse pops one expected record
  always @(negedge clk) begin
    if (frame_done) begin
      chk("fd_single_cycle", {31'd0, fd_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_done: got fc %0d expected none",
                 frame_count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("fd_err_flags", {27'd0, err_flags}, {27'd0, e.flags});
        chk("fd_err_count", {24'd0, err_count}, {24'd0, e.errc});
        chk("fd_frame_count", {16'd0, frame_count}, {16'd0, e.fc});
        chk("fd_locked", {31'd0, locked}, 32'd1);
      end
    end
    fd_prev = frame_done;
  end

  task automatic sample(input logic h, input logic v, input logic d);
    @(negedge clk);
    hs = h;
    vs = v;
    de = d;
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  // Line: sync, back porch to 4, 8 visible, 2+extra front porch
  task automatic gen_line(input logic vsa, input bit vis, input int hsync,
                          input int extra, input int de_n);
    logic vl;
    vl = ~vsa;
    for (int i = 0; i < hsync; i++) sample(1'b0, vl, 1'b0);
    for (int i = hsync; i < 4; i++) sample(1'b1, vl, 1'b0);
    for (int i = 0; i < 8; i++) sample(1'b1, vl, vis && (i < de_n));
    for (int i = 0; i < 2 + extra; i++) sample(1'b1, vl, 1'b0);
  endtask

  // kind: 0 clean, 1 one extra sample, 2 HS width 3, 3 DE for 7 pixels
  task automatic gen_frame(input int first, input int last,
                           input int mline, input int kind);
    for (int l = first; l <= last; l++) begin
      bit m;
      m = (l == mline);
      gen_line(l == 0, (l >= 2) && (l <= 5),
               (m && kind == 2) ? 3 : 2,
               (m && kind == 1) ? 1 : 0,
               (m && kind == 3) ? 7 : 8);
    end
  endtask

  task automatic push(input logic [4:0] f, input logic [7:0] c,
                      input logic [15:0] n);
    exp_t e;
    e.flags = f;
    e.errc = c;
    e.fc = n;
    exp_q.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_locked"}, {31'd0, locked}, 32'd0);
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    chk({tag, "_err_flags"}, {27'd0, err_flags}, 32'd0);
    chk({tag, "_err_count"}, {24'd0, err_count}, 32'd0);
    chk({tag, "_frame_count"}, {16'd0, frame_count}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    pix_en = 1'b0;
    hs = 1'b1;
    vs = 1'b1;
    de = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_zero("reset");
    for (int i = 0; i < 3; i++) sample(1'b1, 1'b1, 1'b0);

    gen_frame(0, 6, -1, 0);
    chk("hlock_not_locked", {31'd0, locked}, 32'd0);
    gen_frame(0, 0, -1, 0);
    chk("locked_after_vs", {31'd0, locked}, 32'd1);
    gen_frame(1, 6, -1, 0);
    push(5'b00000, 8'd0, 16'd1);
    gen_frame(0, 6, -1, 0);
    push(5'b00000, 8'd0, 16'd2);
    gen_frame(0, 6, 3, 1);
    push(5'b01001, 8'd2, 16'd3);
    gen_frame(0, 2, -1, 0);
    chk("err_hold_flags", {27'd0, err_flags}, 32'h09);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_zero("midreset");
    gen_frame(3, 6, -1, 0);
    chk("relock_hlock", {31'd0, locked}, 32'd0);
    chk("relock_no_flags", {27'd0, err_flags}, 32'd0);
    gen_frame(0, 0, -1, 0);
    chk("relock_locked", {31'd0, locked}, 32'd1);
    gen_frame(1, 6, 2, 2);
    push(5'b00010, 8'd1, 16'd1);
    gen_frame(0, 6, 3, 3);
    push(5'b00110, 8'd2, 16'd2);
    gen_frame(0, 6, -1, 0);
    push(5'b00110, 8'd2, 16'd3);
    gen_frame(0, 0, -1, 0);
    for (int i = 0; i < 4; i++) sample(1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);

    chk("queue_drained", exp_q.size(), 32'd0);
    chk("final_err_count", {24'd0, err_count}, 32'd2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
